// File: rtl/serdes_lane_bringup_ctrl.sv
// Reset/bring-up sequencer for one SerDes lane: sequences PMA and PCS resets
// from synchronized lock/detect status and retries on timeout or lost lock.
module serdes_lane_bringup_ctrl #(
    parameter int unsigned PMA_RST_CYCLES = 32,
    parameter int unsigned PCS_RST_CYCLES = 16,
    parameter int unsigned LOCK_FILTER    = 8,
    parameter int unsigned PLL_TIMEOUT    = 1048575,
    parameter int unsigned CDR_TIMEOUT    = 1048575,
    parameter int unsigned TMR_W          = 20
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       restart_i,
    input  logic       pll_lock_i,
    input  logic       signal_detect_i,
    input  logic       cdr_lock_i,
    output logic       pma_rstn_o,
    output logic       pcs_tx_rst_o,
    output logic       pcs_rx_rst_o,
    output logic       tx_ready_o,
    output logic       rx_ready_o,
    output logic [2:0] state_o,
    output logic [7:0] retry_cnt_o,
    output logic       timeout_o
);

    localparam int unsigned FLT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;

    localparam logic [2:0] PMA_RST  = 3'd0;
    localparam logic [2:0] WAIT_PLL = 3'd1;
    localparam logic [2:0] TX_RST   = 3'd2;
    localparam logic [2:0] WAIT_SIG = 3'd3;
    localparam logic [2:0] RX_RST   = 3'd4;
    localparam logic [2:0] WAIT_CDR = 3'd5;
    localparam logic [2:0] LINK_UP  = 3'd6;

    localparam logic [TMR_W-1:0] PMA_LAST = TMR_W'(PMA_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] PCS_LAST = TMR_W'(PCS_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] PLL_LAST = TMR_W'(PLL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CDR_LAST = TMR_W'(CDR_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);

    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic             pll;
    logic             sig;
    logic             cdr;
    logic [2:0]       state_q;
    logic [2:0]       next_state;
    logic [TMR_W-1:0] timer_q;
    logic [FLT_W-1:0] filt_q;
    logic             watched;
    logic             accepted;
    logic             take;
    logic             tmo;

    // Two-flop synchronizers for the asynchronous lane status inputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q1 <= 3'b000;
            sync_q2 <= 3'b000;
        end else begin
            sync_q1 <= {pll_lock_i, signal_detect_i, cdr_lock_i};
            sync_q2 <= sync_q1;
        end
    end

    assign pll = sync_q2[2];
    assign sig = sync_q2[1];
    assign cdr = sync_q2[0];

    // Next-state logic; take marks any state entry, including restart re-entry
    always_comb begin
        next_state = state_q;
        take       = 1'b0;
        tmo        = 1'b0;
        watched    = 1'b0;
        case (state_q)
            WAIT_PLL: watched = pll;
            WAIT_SIG: watched = sig;
            WAIT_CDR: watched = cdr;
            default:  watched = 1'b0;
        endcase
        accepted = watched && (filt_q == FLT_LAST);

        if (restart_i) begin
            next_state = PMA_RST;
            take       = 1'b1;
        end else if (!pll && (state_q inside {TX_RST, WAIT_SIG, RX_RST, WAIT_CDR, LINK_UP})) begin
            next_state = PMA_RST;
            take       = 1'b1;
        end else begin
            case (state_q)
                PMA_RST: begin
                    if (timer_q == PMA_LAST) begin
                        next_state = WAIT_PLL;
                        take       = 1'b1;
                    end
                end
                WAIT_PLL: begin
                    if (accepted) begin
                        next_state = TX_RST;
                        take       = 1'b1;
                    end else if (timer_q == PLL_LAST) begin
                        next_state = PMA_RST;
                        take       = 1'b1;
                        tmo        = 1'b1;
                    end
                end
                TX_RST: begin
                    if (timer_q == PCS_LAST) begin
                        next_state = WAIT_SIG;
                        take       = 1'b1;
                    end
                end
                WAIT_SIG: begin
                    if (accepted) begin
                        next_state = RX_RST;
                        take       = 1'b1;
                    end
                end
                RX_RST: begin
                    if (timer_q == PCS_LAST) begin
                        next_state = WAIT_CDR;
                        take       = 1'b1;
                    end
                end
                WAIT_CDR: begin
                    if (accepted) begin
                        next_state = LINK_UP;
                        take       = 1'b1;
                    end else if (!sig) begin
                        next_state = WAIT_SIG;
                        take       = 1'b1;
                    end else if (timer_q == CDR_LAST) begin
                        next_state = RX_RST;
                        take       = 1'b1;
                        tmo        = 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!sig) begin
                        next_state = WAIT_SIG;
                        take       = 1'b1;
                    end else if (!cdr) begin
                        next_state = RX_RST;
                        take       = 1'b1;
                    end
                end
                default: begin
                    next_state = PMA_RST;
                    take       = 1'b1;
                end
            endcase
        end
    end

    // State, timer, filter and retry registers; outputs decoded from next_state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= PMA_RST;
            timer_q      <= '0;
            filt_q       <= '0;
            retry_cnt_o  <= 8'd0;
            timeout_o    <= 1'b0;
            pma_rstn_o   <= 1'b0;
            pcs_tx_rst_o <= 1'b1;
            pcs_rx_rst_o <= 1'b1;
            tx_ready_o   <= 1'b0;
            rx_ready_o   <= 1'b0;
        end else begin
            state_q <= next_state;

            if (take) begin
                timer_q <= '0;
            end else if (timer_q != TMR_MAX) begin
                timer_q <= timer_q + TMR_W'(1);
            end

            if (take || !watched) begin
                filt_q <= '0;
            end else if (filt_q != FLT_LAST) begin
                filt_q <= filt_q + FLT_W'(1);
            end

            if (tmo && (retry_cnt_o != 8'hFF)) begin
                retry_cnt_o <= retry_cnt_o + 8'd1;
            end
            timeout_o <= tmo;

            pma_rstn_o   <= (next_state != PMA_RST);
            pcs_tx_rst_o <= (next_state inside {PMA_RST, WAIT_PLL, TX_RST});
            pcs_rx_rst_o <= (next_state inside {PMA_RST, WAIT_PLL, TX_RST, WAIT_SIG, RX_RST});
            tx_ready_o   <= (next_state inside {WAIT_SIG, RX_RST, WAIT_CDR, LINK_UP});
            rx_ready_o   <= (next_state == LINK_UP);
        end
    end

    assign state_o = state_q;

endmodule
